// File: rtl/nspi_pkg.sv
// nspi_pkg: shared state type, lane word type and sizing helpers for the N-lane SPI link
package nspi_pkg;
  typedef enum logic [0:0] {IDLE, RECEIVE} rx_state_t;
  localparam int MAX_SPI_SIZE = 16;
  typedef logic [MAX_SPI_SIZE-1:0] lane_word_t;
  function automatic int cnt_width(input int size);
    return $clog2(size + 1);
  endfunction
endpackage

// File: rtl/nspi_sync.sv
// nspi_sync: multi-flop synchroniser, all bits share the same stages so they stay aligned
module nspi_sync #(
  parameter int WIDTH = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] ff;
  always_ff @(posedge clk)
    ff <= !rst ? '0 : {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/nspi_rx.sv
// nspi_rx: oversampling N-lane SPI receiver presenting each word on a valid/ready interface
module nspi_rx
  import nspi_pkg::*;
#(
  parameter int CHANNEL_NUMBER = 3,
  parameter int SPI_SIZE = 8,
  parameter int MSB_FIRST = 1,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     spi_clk,
  input  logic [CHANNEL_NUMBER-1:0]                spi_mosi,
  output logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0]  data_out,
  output logic                                     data_valid,
  input  logic                                     data_ready,
  output logic                                     frame_error,
  output logic                                     overrun,
  output logic                                     busy
);
  localparam int CW = cnt_width(SPI_SIZE);
  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(SPI_SIZE - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
  rx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0] sh, sh_n;
  logic [CHANNEL_NUMBER:0] sync_q;
  logic [CHANNEL_NUMBER-1:0] lanes;
  logic sclk, sclk_d, rise, done, done_n, ferr_n;
  nspi_sync #(.WIDTH(CHANNEL_NUMBER + 1), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .d({spi_mosi, spi_clk}),
    .q(sync_q)
  );
  assign {lanes, sclk} = sync_q;
  assign rise = sclk & ~sclk_d;
  assign busy = state == RECEIVE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    tmr_n = tmr;
    sh_n = sh;
    done_n = 1'b0;
    ferr_n = 1'b0;
    for (int i = 0; i < CHANNEL_NUMBER; i++)
      if (rise) sh_n[i] = MSB_FIRST != 0 ? {sh[i][SPI_SIZE-2:0], lanes[i]} : {lanes[i], sh[i][SPI_SIZE-1:1]};
    if (state == IDLE) begin
      if (rise) begin
        state_n = RECEIVE;
        cnt_n = CW'(1);
        tmr_n = '0;
      end
    end else if (rise) begin
      tmr_n = '0;
      cnt_n = cnt == CNT_LAST ? '0 : cnt + 1'b1;
      state_n = cnt == CNT_LAST ? IDLE : RECEIVE;
      done_n = cnt == CNT_LAST;
    end else if (tmr == TMR_LAST) begin
      state_n = IDLE;
      cnt_n = '0;
      tmr_n = '0;
      sh_n = '0;
      ferr_n = 1'b1;
    end else begin
      tmr_n = tmr + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      tmr <= '0;
      sh <= '0;
      sclk_d <= 1'b0;
      done <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      tmr <= tmr_n;
      sh <= sh_n;
      sclk_d <= sclk;
      done <= done_n;
      frame_error <= ferr_n;
    end
  // A completed word replaces a word being consumed this cycle, otherwise it is dropped if one is pending
  always_ff @(posedge clk)
    if (!rst) begin
      data_out <= '0;
      data_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= done & data_valid & ~data_ready;
      if (done && (!data_valid || data_ready)) begin
        data_out <= sh;
        data_valid <= 1'b1;
      end else if (data_ready) begin
        data_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_nspi_rx.sv
// tb_nspi_rx: scoreboard bench for the N-lane SPI receiver
module tb_nspi_rx;
  logic clk = 1'b0, rst = 1'b0, spi_clk = 1'b0, data_ready = 1'b1, sclk16 = 1'b0;
  logic [2:0] mosi = '0, mosi16 = '0;
  logic [2:0][7:0] data_out;
  logic [2:0][15:0] out16;
  logic data_valid, frame_error, overrun, busy, dv16, fe16, ov16, busy16;
  int total = 0, bad = 0, dv_cycles = 0, ovr_cnt = 0, ferr_cnt = 0, dv16_cnt = 0;
  logic [2:0][7:0] q[$];

  always #5 clk = ~clk;

  nspi_rx #(.CHANNEL_NUMBER(3), .SPI_SIZE(8), .MSB_FIRST(1), .SYNC_STAGES(2), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(mosi), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready), .frame_error(frame_error),
    .overrun(overrun), .busy(busy)
  );

  nspi_rx #(.CHANNEL_NUMBER(3), .SPI_SIZE(16), .MSB_FIRST(0), .SYNC_STAGES(2), .TIMEOUT_CYCLES(64)) dut16 (
    .clk(clk), .rst(rst), .spi_clk(sclk16), .spi_mosi(mosi16), .data_out(out16),
    .data_valid(dv16), .data_ready(1'b1), .frame_error(fe16),
    .overrun(ov16), .busy(busy16)
  );

  always @(negedge clk)
    if (rst) begin
      logic [2:0][7:0] exp;
      dv_cycles += data_valid ? 1 : 0;
      ovr_cnt += overrun ? 1 : 0;
      ferr_cnt += frame_error ? 1 : 0;
      dv16_cnt += dv16 ? 1 : 0;
      if (data_valid && data_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL word_unexpected got=%h expected=none", data_out);
        end else begin
          exp = q.pop_front();
          if (data_out !== exp) begin
            bad++;
            $display("FAIL word got=%h expected=%h", data_out, exp);
          end
        end
      end
    end

  task automatic send_word(input logic [2:0][7:0] w, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      for (int i = 0; i < 3; i++) mosi[i] = w[i][7-k];
      repeat (3) @(posedge clk);
      #1 spi_clk = 1'b1;
      repeat (3) @(posedge clk);
      #1 spi_clk = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 60 && q.size() != 0; n++) @(posedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain pending=%0d expected=0", name, q.size());
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({data_valid, frame_error, overrun, busy} !== 4'b0 || data_out !== '0) begin
      bad++;
      $display("FAIL reset_state got v=%b fe=%b ov=%b busy=%b out=%h expected all zero",
               data_valid, frame_error, overrun, busy, data_out);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_loopback;
    logic [2:0][7:0] w;
    int n, dv0, fe0;
    w[0] = 8'hA5;
    w[1] = 8'h3C;
    w[2] = 8'hFF;
    dv0 = dv_cycles;
    fe0 = ferr_cnt;
    q.push_back(w);
    send_word(w, 7);
    for (int i = 0; i < 3; i++) mosi[i] = w[i][0];
    repeat (3) @(posedge clk);
    #1 spi_clk = 1'b1;
    n = 0;
    while (!data_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL loopback_latency got=%0d expected=4", n);
    end
    repeat (3) @(posedge clk);
    #1 spi_clk = 1'b0;
    drain("loopback");
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (dv_cycles - dv0 != 1 || ferr_cnt != fe0) begin
      bad++;
      $display("FAIL loopback_flags got dv_cycles=%0d fe=%0d expected 1 and 0", dv_cycles - dv0, ferr_cnt - fe0);
    end
  endtask

  task automatic test_lsb16;
    int d0;
    d0 = dv16_cnt;
    for (int k = 0; k < 16; k++) begin
      mosi16 = {2'b00, k == 0};
      repeat (3) @(posedge clk);
      #1 sclk16 = 1'b1;
      repeat (3) @(posedge clk);
      #1 sclk16 = 1'b0;
    end
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (dv16_cnt - d0 != 1) begin
      bad++;
      $display("FAIL lsb16_valid got=%0d expected=1", dv16_cnt - d0);
    end
    total++;
    if (out16 !== {16'h0000, 16'h0000, 16'h0001}) begin
      bad++;
      $display("FAIL lsb16_word got=%h expected=%h", out16, {16'h0000, 16'h0000, 16'h0001});
    end
  endtask

  task automatic test_timeout;
    logic [2:0][7:0] w;
    int f0;
    f0 = ferr_cnt;
    w = 24'h5A_C3_18;
    send_word(w, 5);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_busy_partial got=%b expected=1", busy);
    end
    repeat (80) @(posedge clk);
    #1;
    total++;
    if (ferr_cnt - f0 != 1) begin
      bad++;
      $display("FAIL timeout_frame_error got=%0d expected=1", ferr_cnt - f0);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_busy got=%b expected=0", busy);
    end
    w = 24'h12_34_56;
    q.push_back(w);
    send_word(w, 8);
    drain("timeout_next");
  endtask

  task automatic test_backpressure;
    logic [2:0][7:0] w1, w2;
    int o0;
    o0 = ovr_cnt;
    w1 = 24'hC0_FF_EE;
    w2 = 24'h0B_AD_F0;
    data_ready = 1'b0;
    q.push_back(w1);
    send_word(w1, 8);
    send_word(w2, 8);
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (data_valid !== 1'b1 || data_out !== w1) begin
      bad++;
      $display("FAIL backpressure_hold got v=%b out=%h expected v=1 out=%h", data_valid, data_out, w1);
    end
    total++;
    if (ovr_cnt - o0 != 1) begin
      bad++;
      $display("FAIL backpressure_overrun got=%0d expected=1", ovr_cnt - o0);
    end
    data_ready = 1'b1;
    drain("backpressure");
    @(posedge clk);
    #1;
    total++;
    if (data_valid !== 1'b0) begin
      bad++;
      $display("FAIL backpressure_release got=%b expected=0", data_valid);
    end
  endtask

  task automatic test_reset_mid_word;
    logic [2:0][7:0] w;
    send_word(24'hFF_FF_FF, 4);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (data_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_state got v=%b busy=%b expected 0 0", data_valid, busy);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    w = 24'h00_0F_81;
    q.push_back(w);
    send_word(w, 8);
    drain("midreset_next");
  endtask

  task automatic test_back_to_back;
    logic [2:0][7:0] w;
    int d0, o0;
    d0 = dv_cycles;
    o0 = ovr_cnt;
    data_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      w = 24'($urandom);
      q.push_back(w);
      send_word(w, 8);
    end
    drain("b2b");
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (dv_cycles - d0 != 4 || ovr_cnt != o0) begin
      bad++;
      $display("FAIL b2b_valid_cycles got=%0d ovr=%0d expected 4 and 0", dv_cycles - d0, ovr_cnt - o0);
    end
  endtask

  initial begin
    test_reset;
    test_loopback;
    test_lsb16;
    test_timeout;
    test_backpressure;
    test_reset_mid_word;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
